// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the decoupled instruction fetch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int C_FETCH_ADDR_W = 32;
    localparam int C_FETCH_INST_W = 32;

    // Default-width prefetch entry. The fetch unit derives a parameter-width
    // twin of this so that non-32-bit builds keep the same field layout.
    typedef struct packed {
        logic [C_FETCH_ADDR_W-1:0] pc;
        logic [C_FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

    // The count must be able to represent values from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with push, pop, clear and occupancy count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (w_wr && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // The upstream credit scheme must never let a push reach a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clear) begin
            assert (!(i_push && o_full));
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Decoupled fetch: PC generator, credit-limited memory requests,
//               prefetch FIFO to decode. FETCH_BYPASS_EN adds rsp->out bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  rsp_valid,
    input  logic [INST_WIDTH-1:0] rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_next_pc
);

    localparam int                    CW        = cnt_width(DEPTH);
    localparam int                    SW        = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(4);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]         r_inflight;
    logic [CW-1:0]         r_drop;
    logic [CW-1:0]         w_inflight_next;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_rsp_keep;
    logic                  w_rsp_drop;
    logic                  w_push;
    logic                  w_pop;
    entry_t                w_push_entry;
    entry_t                w_head;

    // Outstanding requests plus buffered entries may never exceed DEPTH, so
    // every response is guaranteed a FIFO slot.
    assign w_credit_ok = (SW'(r_inflight) + SW'(w_count)) < SW'(DEPTH);
    assign req_valid   = r_run && !redirect_valid && w_credit_ok;
    assign req_addr    = r_fetch_pc;
    assign w_issue     = req_valid && req_ready;

    assign w_rsp_drop  = rsp_valid && (r_drop != '0);
    assign w_rsp_keep  = rsp_valid && (r_drop == '0) && !redirect_valid;

    assign w_inflight_next = r_inflight + CW'(w_issue) - CW'(rsp_valid);

    assign w_push_entry.pc   = r_rsp_pc;
    assign w_push_entry.inst = rsp_data;

    assign w_pop = !w_empty && out_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    assign w_bypass  = w_empty && w_rsp_keep;
    assign out_valid = !w_empty || w_bypass;
    assign out_inst  = w_empty ? rsp_data : w_head.inst;
    assign out_pc    = w_empty ? r_rsp_pc : w_head.pc;
    assign w_push    = w_rsp_keep && !(w_bypass && out_ready);
`else
    assign out_valid = !w_empty;
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;
    assign w_push    = w_rsp_keep;
`endif

    assign out_next_pc = out_pc + C_PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= w_inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding belongs to the old path.
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_drop     <= w_inflight_next;
            end else begin
                if (w_issue)    r_fetch_pc <= r_fetch_pc + C_PC_STEP;
                if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + C_PC_STEP;
                if (w_rsp_drop) r_drop     <= r_drop - CW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_valid),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    logic w_unused;
    assign w_unused = w_full;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a
//               fixed-latency in-order instruction memory model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;

    logic        wrap_req_valid;
    logic [31:0] wrap_req_addr;
    logic        wrap_out_valid;
    logic [31:0] wrap_out_inst;
    logic [31:0] wrap_out_pc;
    logic [31:0] wrap_out_next_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t q[$];
    int   cyc      = 0;
    int   lat      = 1;
    bit   model_en = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_next_pc    (out_next_pc)
    );

    fetch_unit #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'hFFFF_FFF8)
    ) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (wrap_req_valid),
        .req_ready      (1'b1),
        .req_addr       (wrap_req_addr),
        .rsp_valid      (1'b0),
        .rsp_data       (32'h0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (wrap_out_valid),
        .out_ready      (1'b0),
        .out_inst       (wrap_out_inst),
        .out_pc         (wrap_out_pc),
        .out_next_pc    (wrap_out_next_pc)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record the handshake about to happen, then drive the
    // memory response due in the new cycle.
    task automatic tick();
        #1;
        if (rst_n && req_valid && req_ready) q.push_back('{addr: req_addr, due: cyc + lat});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (model_en) begin
            rsp_valid = 1'b0;
            if (q.size() > 0 && q[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_data(q[0].addr);
                void'(q.pop_front());
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_out(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check_eq(tag, {31'b0, out_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;

        rst_n          = 1'b0;
        req_ready      = 1'b1;
        out_ready      = 1'b1;
        rsp_valid      = 1'b0;
        rsp_data       = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_valid", {31'b0, req_valid}, 32'h0);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_req_addr", req_addr, 32'h0);
        check_eq("rst_wrap_addr", wrap_req_addr, 32'hFFFF_FFF8);

        // Streaming with 1-cycle memory, plus wrap-around on second instance
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        lat = 1;
        tick();
        check_eq("stream_req_valid", {31'b0, req_valid}, 32'h1);
        check_eq("stream_addr0", req_addr, 32'h0);
        check_eq("wrap_addr0", wrap_req_addr, 32'hFFFF_FFF8);
        tick();
        check_eq("stream_addr1", req_addr, 32'h4);
        check_eq("wrap_addr1", wrap_req_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("stream_addr2", req_addr, 32'h8);
        check_eq("wrap_addr2", wrap_req_addr, 32'h0000_0000);
        wait_out("stream_first_out");
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            check_eq("stream_out_valid", {31'b0, out_valid}, 32'h1);
            check_eq("stream_out_pc", out_pc, exp_pc);
            check_eq("stream_next_pc", out_next_pc, exp_pc + 32'h4);
            check_eq("stream_out_inst", out_inst, mem_data(exp_pc));
            exp_pc = exp_pc + 32'h4;
            tick();
        end

        // Back-pressure: 2-cycle memory, decode stalled
        out_ready = 1'b0;
        do_reset();
        lat = 2;
        repeat (12) tick();
        check_eq("bp_req_valid_low", {31'b0, req_valid}, 32'h0);
        check_eq("bp_out_valid", {31'b0, out_valid}, 32'h1);
        check_eq("bp_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            check_eq("bp_drain_valid", {31'b0, out_valid}, 32'h1);
            check_eq("bp_drain_pc", out_pc, exp_pc);
            check_eq("bp_drain_inst", out_inst, mem_data(exp_pc));
            exp_pc = exp_pc + 32'h4;
            tick();
        end

        // Redirect with three responses still in flight
        do_reset();
        lat       = 4;
        req_ready = 1'b0;
        repeat (2) tick();
        req_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check_eq("redir_req_blocked", {31'b0, req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("redir_req_valid", {31'b0, req_valid}, 32'h1);
        check_eq("redir_req_addr", req_addr, 32'h100);
        check_eq("redir_out_empty", {31'b0, out_valid}, 32'h0);
        wait_out("redir_first_out");
        check_eq("redir_out_pc", out_pc, 32'h100);
        check_eq("redir_out_inst", out_inst, mem_data(32'h100));

        // Redirect colliding with a response and a pop
        do_reset();
        lat = 1;
        wait_out("coll_first_out");
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("coll_out_empty", {31'b0, out_valid}, 32'h0);
        check_eq("coll_req_valid", {31'b0, req_valid}, 32'h1);
        check_eq("coll_req_addr", req_addr, 32'h200);
        wait_out("coll_first_out2");
        check_eq("coll_out_pc", out_pc, 32'h200);
        check_eq("coll_out_inst", out_inst, mem_data(32'h200));

        // Response landing on an empty FIFO
        model_en = 1'b0;
        do_reset();
        repeat (2) tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0013;
        #1;
`ifdef FETCH_BYPASS_EN
        check_eq("byp_same_valid", {31'b0, out_valid}, 32'h1);
        check_eq("byp_same_inst", out_inst, 32'h0000_0013);
        check_eq("byp_same_pc", out_pc, 32'h0);
`else
        check_eq("byp_same_valid", {31'b0, out_valid}, 32'h0);
`endif
        tick();
        rsp_valid = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        check_eq("byp_next_valid", {31'b0, out_valid}, 32'h0);
`else
        check_eq("byp_next_valid", {31'b0, out_valid}, 32'h1);
        check_eq("byp_next_inst", out_inst, 32'h0000_0013);
        check_eq("byp_next_pc", out_pc, 32'h0);
`endif
        model_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the rvMagic pipeline. It replaces the single-cycle PC/IF_ID path with a decoupled fetch:
- a PC generator issues requests to a variable-latency instruction memory over a valid/ready handshake;
- responses land in a DEPTH-entry prefetch FIFO;
- decode consumes {pc, next_pc, inst} through a valid/ready port.

Redirects (branch/jump/jalr resolved in DMEM) flush the FIFO and discard in-flight responses.

## Interface
- ADDR_WIDTH, 32, PC/request address width
- INST_WIDTH, 32, instruction width
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  out  1  fetch request valid
- req_ready  in  1  instruction memory accepts request
- req_addr  out  ADDR_WIDTH  fetch address (word-aligned)
- rsp_valid  in  1  response valid; in order, always accepted
- rsp_data  in  INST_WIDTH  fetched instruction
- redirect_valid  in  1  control-flow redirect (NEXT_ADDR_SEL jumpOrBranch)
- redirect_pc  in  ADDR_WIDTH  redirect target
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts (HDU stall_n)
- out_inst  out  INST_WIDTH  instruction
- out_pc  out  ADDR_WIDTH  its PC
- out_next_pc  out  ADDR_WIDTH  out_pc + 4

## Operation
**State**
- fetch_pc, rsp_pc (ADDR_WIDTH).
- inflight and drop counters, $clog2(DEPTH+1) bits each.
- FIFO of {pc, inst} with count.

**Request issue**
- req_valid = !redirect_valid && (inflight + count < DEPTH).
- req_addr = fetch_pc.
- On req_valid && req_ready: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), inflight += 1.

**Response handling**
- Every rsp_valid decrements inflight.
- If drop > 0: the response is discarded and drop decrements.
- Otherwise {rsp_pc, rsp_data} is pushed and rsp_pc += 4.
- The credit rule guarantees no overflow; a push to a full FIFO is an assertion failure.

**Output**
- out_* present the FIFO head; out_valid = count > 0.
- Pop on out_valid && out_ready.

**Redirect** (highest priority, same cycle)
- FIFO cleared; the pop that cycle is ignored.
- fetch_pc, rsp_pc ← redirect_pc.
- No request is issued; a pending unaccepted request is abandoned. The memory must tolerate req_valid dropping without a handshake.
- drop ← inflight_next, i.e. all remaining in-flight requests.
- A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins.

**Simultaneous events** (no redirect)
- Push and pop in the same cycle leave count unchanged.
- Issue and response in the same cycle leave inflight unchanged.

**Reset**
- rst_n low: req_valid=0, out_valid=0, fetch_pc=rsp_pc=RESET_PC, counters=0, FIFO empty.
- Reset mid-operation discards everything; responses arriving while in reset are ignored.

## Timing
- First req_valid in the first rising edge after rst_n deasserts.
- Response-to-out_valid latency: 1 cycle (registered FIFO).
- Sustained throughput is 1 instruction/cycle when memory latency L ≤ DEPTH−1 (request accept to rsp_valid, in cycles).
- Redirect to first request at the new target: 1 cycle.
- Redirect to first out_valid: L+2 cycles (the 1-cycle issue delay, L cycles of memory latency, the 1-cycle FIFO).
- out_* are stable while out_valid && !out_ready.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and a non-dropped rsp_valid arrives, out_valid/out_inst/out_pc are driven combinationally from the response that cycle.
  - If out_ready is high, the entry is not written into the FIFO.
  - Response-to-decode latency becomes 0 cycles; redirect to first out_valid becomes L+1 cycles.
- Undefined: all outputs come from FIFO registers only (1-cycle latency); no combinational rsp→out path.

## Structure
- Shared package fetch_pkg:
  - typedef fetch_entry_t {pc, inst}.
  - Counter width function.
- ADDR_WIDTH, INST_WIDTH and RV_NOP remain in rv32i_defs.
- One sub-module: sync_fifo (parametrised width/depth; push, pop, clear, count, full, empty; async active-low reset), instantiated with fetch_entry_t width.

## Test plan
- **Reset/streaming:** RESET_PC=0, req_ready=1, 1-cycle memory → req_addr 0,4,8,…; out_pc 0,4,8 one per cycle; out_next_pc = out_pc+4.
- **Back-pressure:** out_ready=0 with 2-cycle memory, DEPTH=4 → req_valid deasserts once inflight+count=4; exactly 4 entries held; releasing out_ready drains 0,4,8,12 in order.
- **Redirect with in-flight responses:** 3 requests outstanding, then redirect_pc=0x100 → the 3 old responses are dropped; next out_pc=0x100; no stale instruction reaches out.
- **Redirect colliding with response and pop:** redirect, rsp_valid and out_ready all high in the same cycle → response discarded, FIFO empty next cycle, req_addr=redirect_pc the following cycle.
- **Wrap-around:** RESET_PC=32'hFFFF_FFF8 → req_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Bypass:** with FETCH_BYPASS_EN, empty FIFO, rsp_valid with data 0x00000013 → out_valid high in the same cycle with out_inst=0x00000013. Without the macro, out_valid rises one cycle later.
